// File: rtl/audio_pkg.sv
// Shared constants, FSM state type and sample-format helpers for the badge audio mixer.
// Offset-binary <-> two's-complement conversion is a plain MSB inversion.
package audio_pkg;

    localparam int BITDEPTH   = 14;
    localparam int MIDSCALE   = 1 << (BITDEPTH - 1);
    localparam int UNITY_GAIN = 64;
    localparam int GAIN_SHIFT = 6;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCALE,
        CLIP
    } mix_state_t;

    function automatic logic signed [BITDEPTH-1:0] to_signed(
        input logic [BITDEPTH-1:0] x
    );
        return {~x[BITDEPTH-1], x[BITDEPTH-2:0]};
    endfunction

    function automatic logic [BITDEPTH-1:0] to_offset(
        input logic signed [BITDEPTH-1:0] x
    );
        return {~x[BITDEPTH-1], x[BITDEPTH-2:0]};
    endfunction

endpackage

// File: rtl/pdm_dac.sv
// First-order delta-sigma modulator turning an offset-binary sample into a 1-bit stream.
// Pulse density equals din / 2^BITDEPTH; the carry of the phase accumulator is the output.
module pdm_dac #(
    parameter int BITDEPTH = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITDEPTH-1:0] din,
    output logic                pdm_out
);

    logic [BITDEPTH:0] acc_pdm;

    // Phase accumulation every clock; the carry bit is emitted one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_pdm <= '0;
            pdm_out <= 1'b0;
        end else begin
            acc_pdm <= {1'b0, acc_pdm[BITDEPTH-1:0]} + {1'b0, din};
            pdm_out <= acc_pdm[BITDEPTH];
        end
    end

endmodule

// File: rtl/audio_mixer.sv
// Multi-voice mixer: snapshot voices on strobe, sum enabled ones, apply gain, saturate.
// Define AUDIO_MIXER_PDM_EN to add the pdm_out delta-sigma output.
module audio_mixer
    import audio_pkg::*;
#(
    parameter int VOICES   = 4,
    parameter int BITDEPTH = audio_pkg::BITDEPTH,
    parameter int GAINBITS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_strobe,
    input  logic [VOICES*BITDEPTH-1:0] voice_in,
    input  logic [VOICES-1:0]          voice_enable,
    input  logic [GAINBITS-1:0]        master_volume,
    output logic [BITDEPTH-1:0]        out,
    output logic                       out_valid,
    output logic                       clip,
    output logic                       overrun
`ifdef AUDIO_MIXER_PDM_EN
    ,
    output logic                       pdm_out
`endif
);

    localparam int IDXW  = $clog2(VOICES);
    localparam int ACCW  = BITDEPTH + IDXW;
    localparam int PRODW = ACCW + GAINBITS + 1;

    localparam logic [BITDEPTH-1:0] MID =
        {1'b1, {(BITDEPTH-1){1'b0}}};
    localparam logic signed [PRODW-1:0] SAT_MAX =
        PRODW'((1 << (BITDEPTH-1)) - 1);
    localparam logic signed [PRODW-1:0] SAT_MIN =
        -SAT_MAX - PRODW'(1);

    mix_state_t state, state_nxt;

    logic [VOICES*BITDEPTH-1:0] snap_voice;
    logic [VOICES-1:0]          snap_en;
    logic [GAINBITS-1:0]        snap_vol;
    logic [IDXW-1:0]            idx;
    logic signed [ACCW-1:0]     acc;
    logic signed [PRODW-1:0]    scaled;

    logic [BITDEPTH-1:0]        cur;
    logic signed [BITDEPTH-1:0] cur_s;
    logic signed [ACCW-1:0]     term;
    logic signed [PRODW-1:0]    prod;
    logic signed [BITDEPTH-1:0] sat;
    logic                       sat_hit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: one ACCUM cycle per voice, then SCALE and CLIP
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (sample_strobe) state_nxt = ACCUM;
            ACCUM: if (idx == IDXW'(VOICES-1)) state_nxt = SCALE;
            SCALE: state_nxt = CLIP;
            CLIP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-voice term, gain product and saturation
    always_comb begin
        cur     = snap_voice[idx*BITDEPTH +: BITDEPTH];
        cur_s   = {~cur[BITDEPTH-1], cur[BITDEPTH-2:0]};
        term    = snap_en[idx] ? ACCW'(cur_s) : '0;
        prod    = PRODW'(acc) * $signed({{(PRODW-GAINBITS){1'b0}}, snap_vol});
        sat     = scaled[BITDEPTH-1:0];
        sat_hit = 1'b0;
        if (scaled > SAT_MAX) begin
            sat     = SAT_MAX[BITDEPTH-1:0];
            sat_hit = 1'b1;
        end else if (scaled < SAT_MIN) begin
            sat     = SAT_MIN[BITDEPTH-1:0];
            sat_hit = 1'b1;
        end
    end

    // Datapath: snapshot, accumulate, scale, register the saturated result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_voice <= '0;
            snap_en    <= '0;
            snap_vol   <= '0;
            idx        <= '0;
            acc        <= '0;
            scaled     <= '0;
            out        <= MID;
            out_valid  <= 1'b0;
            clip       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= sample_strobe && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (sample_strobe) begin
                        snap_voice <= voice_in;
                        snap_en    <= voice_enable;
                        snap_vol   <= master_volume;
                        acc        <= '0;
                        idx        <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + term;
                    idx <= idx + IDXW'(1);
                end
                SCALE: begin
                    scaled <= prod >>> GAIN_SHIFT;
                end
                CLIP: begin
                    out       <= {~sat[BITDEPTH-1], sat[BITDEPTH-2:0]};
                    clip      <= sat_hit;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef AUDIO_MIXER_PDM_EN
    pdm_dac #(
        .BITDEPTH (BITDEPTH)
    ) u_pdm (
        .clk     (clk),
        .rst     (rst),
        .din     (out),
        .pdm_out (pdm_out)
    );
`endif

endmodule

// File: doc/audio_mixer.md
# audio_mixer

Multi-voice output mixer for the badge audio path. Sits directly downstream of the per-voice attack/release amplifier stages. Once per audio sample it snapshots every voice's 14-bit offset-binary sample and sums the enabled voices in signed form. It then applies a master gain, saturates the result and presents one offset-binary sample for the DAC stage.

## Interface
Parameters:
- VOICES, 4: number of voice inputs (power of two, ≥2)
- BITDEPTH, 14: sample width, offset binary, midscale = 2^(BITDEPTH-1)
- GAINBITS, 8: master_volume width; unity gain = 64

Ports:
- clk  in  1  audio system clock (8 MHz)
- rst  in  1  asynchronous, active-high reset
- sample_strobe  in  1  one-cycle pulse per sample (31,250 Hz)
- voice_in  in  VOICES*BITDEPTH  packed voice samples; voice i at [i*BITDEPTH +: BITDEPTH]
- voice_enable  in  VOICES  per-voice mix enable, sampled with voice_in
- master_volume  in  GAINBITS  gain = master_volume/64
- out  out  BITDEPTH  mixed sample, offset binary, held between updates
- out_valid  out  1  one-cycle pulse when out updates
- clip  out  1  high while current out was saturated; updates with out
- overrun  out  1  one-cycle pulse when a strobe arrives while busy

## Operation
- FSM states: IDLE, ACCUM, SCALE, CLIP.
- IDLE:
  - On sample_strobe, snapshot voice_in, voice_enable and master_volume.
  - Clear the accumulator, set voice index = 0, go to ACCUM.
- ACCUM: lasts VOICES cycles, one voice per cycle.
  - Convert the sample to signed by inverting its MSB.
  - Add it to acc if the voice is enabled; otherwise add 0.
  - acc width = BITDEPTH + log2(VOICES) signed (16 bits at default), so the sum cannot overflow.
  - After index VOICES-1, go to SCALE.
- SCALE:
  - prod = acc * {1'b0, master_volume}, signed, full width.
  - Arithmetic shift right by 6 (floor).
  - Go to CLIP.
- CLIP:
  - Saturate to [-2^(BITDEPTH-1), 2^(BITDEPTH-1)-1].
  - Invert MSB and register into out.
  - Pulse out_valid; set clip = 1 if saturation occurred.
  - Go to IDLE.
- A sample_strobe seen in any state other than IDLE:
  - The strobe is ignored and overrun pulses the next cycle.
  - The in-flight sample completes unaffected.
- A strobe in the same cycle as the CLIP→IDLE transition counts as busy (overrun).
- master_volume = 0 gives midscale output with clip = 0.
- All voices disabled gives midscale output.

## Timing
- Strobe sampled at edge k.
- ACCUM occupies cycles k+1..k+VOICES.
- SCALE at k+VOICES+1.
- out, clip and out_valid update at edge k+VOICES+2, i.e. 6 cycles at default VOICES.
- Minimum strobe spacing: VOICES+3 cycles.
- Reset values: out = 2^(BITDEPTH-1) (0x2000), out_valid = 0, clip = 0, overrun = 0, FSM = IDLE, acc = 0, pdm_out = 0.
- Reset asserted mid-operation aborts the sample immediately. No out_valid follows.
- Inputs only need to be stable at the strobe edge.

## Configuration
- AUDIO_MIXER_PDM_EN defined:
  - Adds output port pdm_out (1 bit): first-order delta-sigma modulation of out, updated every clk.
  - Modulator accumulator is BITDEPTH+1 bits: acc_pdm <= acc_pdm[BITDEPTH-1:0] + out, and pdm_out <= acc_pdm carry bit.
  - Pulse density equals out/2^BITDEPTH.
- Undefined: no pdm_out port and no modulator logic. out feeds an external DAC.

## Structure
- Shared package audio_pkg holds:
  - BITDEPTH, the midscale constant, and the unity-gain constant (64) with its shift (6).
  - The FSM state enum.
  - A to_signed/to_offset conversion (MSB inversion).
- One sub-module, pdm_dac, holds the delta-sigma modulator. It is instantiated only under AUDIO_MIXER_PDM_EN.

## Test plan
- Reset check: assert rst mid-ACCUM → out = 0x2000, out_valid = 0, clip = 0 immediately; no out_valid pulse afterward.
- Unity mix:
  - All voices 0x2000, enable 4'b1111, vol 64, strobe → out = 0x2000, clip = 0, out_valid exactly 6 cycles after the strobe edge.
  - voice0 = 0x2100 → 0x2100.
  - Then vol 128 → 0x2200; vol 32 → 0x2080.
- Saturation:
  - All voices 0x3FFF, vol 64 → out = 0x3FFF, clip = 1.
  - All voices 0x0000 → out = 0x0000, clip = 1.
  - Next strobe with voices at midscale → clip = 0.
- Enable mask: voice0 = 0x2000, voices1-3 = 0x3FFF, enable 4'b0001 → out = 0x2000, clip = 0.
- Overrun: second strobe 2 cycles after the first → overrun pulses one cycle, first result is correct, only one out_valid.
- PDM (macro defined): out held 0x2000 for 16384 cycles → pdm_out high 8192 ±1 cycles; out held 0x3000 → 12288 ±1.
